// File: rtl/q_sys_rxm_dat_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : q_sys_rxm_dat_ctrl_if
// Purpose  : Bundles the Avalon-MM slave bus, the RXM producer stream and the
//            interrupt line of the RXM data receive controller.
// Ports    : address/chipselect/read/write/writedata/readdata - Avalon-MM slave
//            in_data/in_valid/in_ready                        - producer stream
//            irq                                              - level interrupt
// Revision : 1.0 - initial release
// ============================================================================
interface q_sys_rxm_dat_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              irq;

  // Bus master / producer side (interconnect, RXM front end, testbench)
  modport master (
    output address, chipselect, read, write, writedata, in_data, in_valid,
    input  readdata, in_ready, irq
  );

  // Controller side
  modport slave (
    input  address, chipselect, read, write, writedata, in_data, in_valid,
    output readdata, in_ready, irq
  );
endinterface
`default_nettype wire

// File: rtl/q_sys_rxm_dat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : q_sys_rxm_dat_ctrl
// Purpose  : Avalon-MM slave receive controller for the RXM data path. Buffers
//            producer words in a small FIFO that the CPU pops through the DATA
//            register, tracks overrun/underflow and raises a level interrupt.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            bus      - slave modport: Avalon-MM registers
//                       (0 DATA, 1 STATUS, 2 CONTROL, 3 OVF_COUNT),
//                       producer stream (in_data/in_valid/in_ready), irq
// Revision : 1.0 - initial release
// ============================================================================
module q_sys_rxm_dat_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  wire                 clk,
  input  wire                 reset_n,
  q_sys_rxm_dat_ctrl_if.slave bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_STAT = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL = 2'd2;
  localparam logic [1:0] c_ADDR_OVF  = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q,  count_d;
  logic               enable_q, enable_d;
  logic               irq_en_q, irq_en_d;
  logic               ovr_q,    ovr_d;
  logic               udf_q,    udf_d;
  logic               irq_q,    irq_d;
  logic [15:0]        ovf_q,    ovf_d;
  logic [31:0]        rdata_q,  rdata_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic        w_rd, w_wr, w_empty, w_full;
  logic        w_pop, w_push, w_ovrn, w_flush;
  logic        w_clr_ovr, w_clr_udf, w_udf_evt;
  logic [31:0] w_head, w_status;
  logic        w_unused_wd;

  assign w_rd    = bus.chipselect & bus.read;
  assign w_wr    = bus.chipselect & bus.write;
  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_CNT_W'(DEPTH));

  // A pop frees a slot on the same edge, so a full FIFO can still accept
  // a word when it is being read.
  assign w_pop     = w_rd & (bus.address == c_ADDR_DATA) & ~w_empty;
  assign w_push    = bus.in_valid & enable_q & (~w_full | w_pop);
  assign w_ovrn    = bus.in_valid & enable_q & w_full & ~w_pop;
  assign w_flush   = w_wr & (bus.address == c_ADDR_CTRL) & bus.writedata[2];
  assign w_clr_ovr = w_wr & (bus.address == c_ADDR_STAT) & bus.writedata[24];
  assign w_clr_udf = w_wr & (bus.address == c_ADDR_STAT) & bus.writedata[25];
  assign w_udf_evt = w_rd & (bus.address == c_ADDR_DATA) & w_empty;

  // Only control/clear bits of writedata carry meaning.
  assign w_unused_wd = ^{bus.writedata[31:26], bus.writedata[23:3]};

  always_comb begin
    w_head                = '0;
    w_head[DATA_W-1:0]    = mem_q[rd_ptr_q];
    w_status              = '0;
    w_status[c_CNT_W-1:0] = count_q;
    w_status[16]          = w_empty;
    w_status[17]          = w_full;
    w_status[24]          = ovr_q;
    w_status[25]          = udf_q;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;

    // Flush wins over any push/pop in the same cycle.
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_CNT_W'(1);
        2'b01:   count_d = count_q - c_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (w_wr && (bus.address == c_ADDR_CTRL)) begin
      enable_d = bus.writedata[0];
      irq_en_d = bus.writedata[1];
    end

    // Set beats clear on the sticky bits.
    ovr_d = (ovr_q & ~w_clr_ovr) | w_ovrn;
    udf_d = (udf_q & ~w_clr_udf) | w_udf_evt;

    // A clear coinciding with an overrun leaves exactly that one overrun counted.
    if (w_wr && (bus.address == c_ADDR_OVF)) begin
      ovf_d = w_ovrn ? 16'd1 : 16'd0;
    end else if (w_ovrn && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end

    if (w_rd) begin
      case (bus.address)
        c_ADDR_DATA: rdata_d = w_empty ? 32'd0 : w_head;
        c_ADDR_STAT: rdata_d = w_status;
        c_ADDR_CTRL: rdata_d = {30'd0, irq_en_q, enable_q};
        default:     rdata_d = {16'd0, ovf_q};
      endcase
    end

    // Interrupt reflects the state as it stood before this edge.
    irq_d = irq_en_q & (~w_empty | ovr_q);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovr_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
      ovf_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      ovr_q    <= ovr_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_push && !w_flush) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.readdata = rdata_q;
  assign bus.irq      = irq_q;
  assign bus.in_ready = enable_q & ~w_full;

endmodule
`default_nettype wire

// File: tb/tb_q_sys_rxm_dat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_q_sys_rxm_dat_ctrl
// Purpose  : Self-checking bench for q_sys_rxm_dat_ctrl: table-driven fill and
//            drain, hand-written corner sequences, and random traffic compared
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_q_sys_rxm_dat_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  q_sys_rxm_dat_ctrl_if #(.DATA_W(DATA_W)) bus ();

  q_sys_rxm_dat_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: FIFO as a queue, registers as plain variables.
  // --------------------------------------------------------------------------
  logic [31:0] m_q[$];
  bit          m_en, m_ien, m_ovr, m_udf, m_irq, m_rdy;
  int          m_ovf;
  logic [31:0] m_rd;

  task automatic m_reset();
    m_q.delete();
    m_en = 0; m_ien = 0; m_ovr = 0; m_udf = 0; m_irq = 0; m_rdy = 0;
    m_ovf = 0; m_rd = '0;
  endtask

  task automatic m_step(input logic [1:0] a, input bit cs, input bit rd, input bit wr,
                        input logic [31:0] wd, input bit iv, input logic [31:0] id);
    int          n     = m_q.size();
    bit          full  = (n == DEPTH);
    bit          empty = (n == 0);
    bit          rdd   = cs && rd;
    bit          wrr   = cs && wr;
    bit          pop   = rdd && (a == 0) && !empty;
    bit          push  = iv && m_en && (!full || pop);
    bit          ovrn  = iv && m_en && full && !pop;
    bit          flush = wrr && (a == 2) && wd[2];
    logic [31:0] st;
    m_irq = m_ien && (!empty || m_ovr);
    if (rdd) begin
      case (a)
        2'd0: m_rd = empty ? 32'd0 : m_q[0];
        2'd1: begin
          st = 32'(n); st[16] = empty; st[17] = full; st[24] = m_ovr; st[25] = m_udf;
          m_rd = st;
        end
        2'd2: m_rd = {30'd0, m_ien, m_en};
        default: m_rd = 32'(m_ovf);
      endcase
    end
    if (flush) m_q.delete();
    else begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(id);
    end
    m_ovr = (m_ovr && !(wrr && a == 2'd1 && wd[24])) || ovrn;
    m_udf = (m_udf && !(wrr && a == 2'd1 && wd[25])) || (rdd && a == 2'd0 && empty);
    if (wrr && a == 2'd3) m_ovf = ovrn ? 1 : 0;
    else if (ovrn && m_ovf < 65535) m_ovf++;
    if (wrr && a == 2'd2) begin m_en = wd[0]; m_ien = wd[1]; end
    m_rdy = m_en && (m_q.size() < DEPTH);
  endtask

  // --------------------------------------------------------------------------
  // Drivers (called at 1 time unit after a rising edge)
  // --------------------------------------------------------------------------
  task automatic drive(input logic [1:0] a, input bit cs, input bit rd, input bit wr,
                       input logic [31:0] wd, input bit iv, input logic [31:0] id);
    bus.address = a; bus.chipselect = cs; bus.read = rd; bus.write = wr;
    bus.writedata = wd; bus.in_valid = iv; bus.in_data = id;
    m_step(a, cs, rd, wr, wd, iv, id);
    @(posedge clk); #1;
    bus.chipselect = 0; bus.read = 0; bus.write = 0; bus.in_valid = 0;
  endtask

  task automatic rdreg(input logic [1:0] a);               drive(a, 1, 1, 0, 0, 0, 0);  endtask
  task automatic wrreg(input logic [1:0] a, input logic [31:0] wd); drive(a, 1, 0, 1, wd, 0, 0); endtask
  task automatic push(input logic [31:0] id);              drive(0, 0, 0, 0, 0, 1, id); endtask
  task automatic idle();                                   drive(0, 0, 0, 0, 0, 0, 0);  endtask

  task automatic do_reset();
    reset_n = 0;
    bus.address = 0; bus.chipselect = 0; bus.read = 0; bus.write = 0;
    bus.writedata = 0; bus.in_valid = 0; bus.in_data = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    m_reset();
  endtask

  typedef struct {
    logic [1:0]  a;
    bit          rd;
    bit          wr;
    logic [31:0] wd;
    bit          iv;
    logic [31:0] id;
    logic [31:0] e_rd;
    bit          e_irq;
    bit          e_rdy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Fill-then-drain vectors
    tbl[0]  = '{2'd2, 0, 1, 32'd1, 0, 32'd0,          32'h0000_0000, 0, 1};
    tbl[1]  = '{2'd0, 0, 0, 32'd0, 1, 32'hA5A5_0001,  32'h0000_0000, 0, 1};
    tbl[2]  = '{2'd0, 0, 0, 32'd0, 1, 32'hA5A5_0002,  32'h0000_0000, 0, 1};
    tbl[3]  = '{2'd0, 0, 0, 32'd0, 1, 32'hA5A5_0003,  32'h0000_0000, 0, 1};
    tbl[4]  = '{2'd0, 0, 0, 32'd0, 1, 32'hA5A5_0004,  32'h0000_0000, 0, 0};
    tbl[5]  = '{2'd1, 1, 0, 32'd0, 0, 32'd0,          32'h0002_0004, 0, 0};
    tbl[6]  = '{2'd0, 1, 0, 32'd0, 0, 32'd0,          32'hA5A5_0001, 0, 1};
    tbl[7]  = '{2'd0, 1, 0, 32'd0, 0, 32'd0,          32'hA5A5_0002, 0, 1};
    tbl[8]  = '{2'd0, 1, 0, 32'd0, 0, 32'd0,          32'hA5A5_0003, 0, 1};
    tbl[9]  = '{2'd0, 1, 0, 32'd0, 0, 32'd0,          32'hA5A5_0004, 0, 1};
    tbl[10] = '{2'd0, 1, 0, 32'd0, 0, 32'd0,          32'h0000_0000, 0, 1};
    tbl[11] = '{2'd1, 1, 0, 32'd0, 0, 32'd0,          32'h0201_0000, 0, 1};

    // ---- Reset state and fill/drain table ----
    do_reset();
    chk("reset.rd",  bus.readdata, 32'd0);
    chk("reset.irq", 32'(bus.irq), 32'd0);
    chk("reset.rdy", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].a, tbl[i].rd | tbl[i].wr, tbl[i].rd, tbl[i].wr, tbl[i].wd,
            tbl[i].iv, tbl[i].id);
      chk($sformatf("t1[%0d].rd", i),  bus.readdata,      tbl[i].e_rd);
      chk($sformatf("t1[%0d].irq", i), 32'(bus.irq),      32'(tbl[i].e_irq));
      chk($sformatf("t1[%0d].rdy", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
    end

    // ---- Overrun counting, sticky clear, coinciding clear/set ----
    do_reset();
    wrreg(2, 1);
    for (int i = 1; i <= 7; i++) push(32'hA5A5_0000 + 32'(i));
    rdreg(3); chk("t2.ovf", bus.readdata, 32'd3);
    rdreg(1); chk("t2.stat", bus.readdata, 32'h0102_0004);
    wrreg(1, 32'h0100_0000);
    rdreg(1); chk("t2.stat_clr", bus.readdata, 32'h0002_0004);
    drive(3, 1, 0, 1, 0, 1, 32'h8);
    rdreg(3); chk("t2.ovf_clr_set", bus.readdata, 32'd1);
    drive(1, 1, 0, 1, 32'h0100_0000, 1, 32'h9);
    rdreg(1); chk("t2.ovr_set_wins", bus.readdata, 32'h0102_0004);
    for (int i = 1; i <= 4; i++) begin
      rdreg(0); chk($sformatf("t2.word%0d", i), bus.readdata, 32'hA5A5_0000 + 32'(i));
    end

    // ---- Pop and push together on a full FIFO ----
    do_reset();
    wrreg(2, 1);
    for (int i = 1; i <= 4; i++) push(32'hA5A5_0000 + 32'(i));
    drive(0, 1, 1, 0, 0, 1, 32'hBEEF);
    chk("t3.rd", bus.readdata, 32'hA5A5_0001);
    chk("t3.rdy", 32'(bus.in_ready), 32'd0);
    rdreg(1); chk("t3.stat", bus.readdata, 32'h0002_0004);
    rdreg(3); chk("t3.ovf", bus.readdata, 32'd0);
    for (int i = 2; i <= 4; i++) begin
      rdreg(0); chk($sformatf("t3.word%0d", i), bus.readdata, 32'hA5A5_0000 + 32'(i));
    end
    rdreg(0); chk("t3.new_word", bus.readdata, 32'hBEEF);

    // ---- Read of empty FIFO with a push in the same cycle ----
    do_reset();
    wrreg(2, 1);
    drive(0, 1, 1, 0, 0, 1, 32'h1234);
    chk("t4.rd", bus.readdata, 32'd0);
    rdreg(1); chk("t4.stat", bus.readdata, 32'h0200_0001);
    rdreg(0); chk("t4.word", bus.readdata, 32'h1234);

    // ---- Interrupt timing and flush ----
    do_reset();
    wrreg(2, 3);  chk("t5.irq0", 32'(bus.irq), 32'd0);
    push(32'h11); chk("t5.irq_push", 32'(bus.irq), 32'd0);
    idle();       chk("t5.irq_hi", 32'(bus.irq), 32'd1);
    rdreg(0);     chk("t5.rd", bus.readdata, 32'h11);
                  chk("t5.irq_pop", 32'(bus.irq), 32'd1);
    idle();       chk("t5.irq_lo", 32'(bus.irq), 32'd0);
    push(1); push(2); push(3);
    wrreg(2, 7);
    rdreg(1);     chk("t5.flush_stat", bus.readdata, 32'h0001_0000);
                  chk("t5.irq_flush", 32'(bus.irq), 32'd0);
    rdreg(2);     chk("t5.ctrl", bus.readdata, 32'd3);

    // ---- Disabled input, then asynchronous reset mid-burst ----
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push(32'h100 + 32'(i));
      chk($sformatf("t6.rdy%0d", i), 32'(bus.in_ready), 32'd0);
    end
    rdreg(1); chk("t6.stat", bus.readdata, 32'h0001_0000);
    rdreg(3); chk("t6.ovf", bus.readdata, 32'd0);
    wrreg(2, 3);
    push(32'h1);
    push(32'h2);
    drive(1, 1, 1, 0, 0, 1, 32'h3);
    chk("t6.pre_rd", bus.readdata, 32'h0000_0002);
    chk("t6.pre_irq", 32'(bus.irq), 32'd1);
    bus.in_valid = 1; bus.in_data = 32'h4;
    #1 reset_n = 0;
    #1;
    chk("t6.rst_rd",  bus.readdata, 32'd0);
    chk("t6.rst_irq", 32'(bus.irq), 32'd0);
    chk("t6.rst_rdy", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 0;
    @(posedge clk); #1 reset_n = 1;
    m_reset();
    rdreg(1); chk("t6.post_stat", bus.readdata, 32'h0001_0000);

    // ---- Random traffic against the reference model ----
    do_reset();
    wrreg(2, 1);
    for (int c = 0; c < 3000; c++) begin
      int          op  = $urandom_range(0, 9);
      bit          iv  = ($urandom_range(0, 99) < 60);
      logic [31:0] id  = $urandom;
      bit          cs  = ($urandom_range(0, 7) != 0);
      logic [1:0]  a   = 2'($urandom_range(0, 3));
      logic [31:0] wd  = $urandom;
      if (op <= 3) drive(a, 0, 0, 0, wd, iv, id);
      else if (op <= 6) drive(a, cs, 1, 0, wd, iv, id);
      else if (op == 7) begin
        wd[0] = ($urandom_range(0, 5) != 0);
        wd[2] = ($urandom_range(0, 7) == 0);
        drive(2, cs, 0, 1, wd, iv, id);
      end else if (op == 8) drive(1, cs, 0, 1, wd, iv, id);
      else drive($urandom_range(0, 1) ? 2'd3 : 2'd0, cs, 0, 1, wd, iv, id);
      chk("rnd.rd",  bus.readdata, m_rd);
      chk("rnd.irq", 32'(bus.irq), 32'(m_irq));
      chk("rnd.rdy", 32'(bus.in_ready), 32'(m_rdy));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
